// File: rtl/arith_pkg.sv
// Shared arithmetic-path definitions.
//   WIDTH_DEFAULT : default operand width for the shift-based arithmetic blocks
//   state_t       : control FSM states for the sequential shift/add engines
//   prod_w()      : full product width for a given operand width
package arith_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A WIDTH x WIDTH unsigned product needs exactly twice the operand width.
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/shift_add_stage.sv
// One shift-and-add iteration of the multiplier (purely combinational).
//   acc        : running partial product (2*WIDTH)
//   mcand      : multiplicand shifted to the current bit weight (2*WIDTH)
//   mplr       : remaining multiplier bits, LSB is the bit being consumed (WIDTH)
//   acc_next   : acc plus mcand when the current multiplier bit is set
//   mcand_next : mcand moved up one bit weight
//   mplr_next  : mplr with the consumed bit dropped
module shift_add_stage
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [prod_w(WIDTH)-1:0] acc,
  input  logic [prod_w(WIDTH)-1:0] mcand,
  input  logic [WIDTH-1:0]         mplr,
  output logic [prod_w(WIDTH)-1:0] acc_next,
  output logic [prod_w(WIDTH)-1:0] mcand_next,
  output logic [WIDTH-1:0]         mplr_next
);

  // The sum never wraps: the largest product (2^WIDTH-1)^2 fits in 2*WIDTH
  // bits, and the bit shifted out of mcand is always zero because only
  // WIDTH shifts are ever applied to a WIDTH-bit value.
  always_comb begin
    acc_next   = mplr[0] ? (acc + mcand) : acc;
    mcand_next = mcand << 1;
    mplr_next  = mplr >> 1;
  end

endmodule

// File: rtl/shift_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// One operand pair is captured per accepted start; one multiplier bit is
// consumed per clock, so every operation takes exactly WIDTH iterations.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset
//   start        : request, accepted only when not busy (IDLE or DONE)
//   multiplicand : operand A, captured on the accepted start edge
//   multiplier   : operand B, captured on the accepted start edge
//   busy         : high while iterating
//   done         : one-cycle pulse, product refreshed in the same cycle
//   product      : A*B of the last completed operation, held until the next
module shift_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [WIDTH-1:0]         multiplicand,
  input  logic [WIDTH-1:0]         multiplier,
  output logic                     busy,
  output logic                     done,
  output logic [prod_w(WIDTH)-1:0] product
);

  localparam int PW    = prod_w(WIDTH);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_next;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand_sh;
  logic [WIDTH-1:0] mplr;
  logic [CNT_W-1:0] cnt;

  logic [PW-1:0]    acc_nx;
  logic [PW-1:0]    mcand_nx;
  logic [WIDTH-1:0] mplr_nx;

  logic accept;
  logic last_iter;
  logic busy_d;
  logic done_d;

  // A request is honoured from IDLE and also from DONE, which gives
  // back-to-back operation without a dead cycle in between.
  assign accept    = start && (state != RUN);
  assign last_iter = (state == RUN) && (cnt == CNT_LAST);

  shift_add_stage #(
    .WIDTH (WIDTH)
  ) u_stage (
    .acc        (acc),
    .mcand      (mcand_sh),
    .mplr       (mplr),
    .acc_next   (acc_nx),
    .mcand_next (mcand_nx),
    .mplr_next  (mplr_nx)
  );

  // State register; busy/done are registered from the next state so the
  // outputs carry no combinational path from start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_d;
      done  <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_next == RUN);
    done_d = (state_next == DONE);
  end

  // Datapath: operand capture, one iteration per RUN cycle, and the product
  // register which is loaded with the sum that includes the final iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mcand_sh <= '0;
      mplr     <= '0;
      cnt      <= '0;
      product  <= '0;
    end else if (accept) begin
      acc      <= '0;
      mcand_sh <= {{(PW - WIDTH){1'b0}}, multiplicand};
      mplr     <= multiplier;
      cnt      <= '0;
    end else if (state == RUN) begin
      acc      <= acc_nx;
      mcand_sh <= mcand_nx;
      mplr     <= mplr_nx;
      cnt      <= cnt + CNT_W'(1);
      if (last_iter) begin
        product <= acc_nx;
      end
    end
  end

endmodule

// File: tb/tb_shift_multiplier.sv
module tb_shift_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  shift_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation is a (A,B) pair plus a countdown of
  // remaining clock edges; the product appears as plain A*B when it expires.
  int             remaining = 0;
  int             pa = 0;
  int             pb = 0;
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  logic [2*W-1:0] exp_product = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining   = 0;
      exp_busy    = 1'b0;
      exp_done    = 1'b0;
      exp_product = '0;
    end else begin
      exp_done = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          exp_product = (2*W)'(pa * pb);
          exp_done    = 1'b1;
        end
      end else if (start) begin
        pa        = int'(multiplicand);
        pb        = int'(multiplier);
        remaining = W;
      end
      exp_busy = (remaining > 0);
    end
  end

  always @(posedge clk) started <= 1'b1;

  always @(negedge clk) begin
    if (started) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      check("product", 32'(product), 32'(exp_product));
      if (busy && done) check("busy_and_done", 32'd1, 32'd0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("timeout_idle", 32'd0, 32'd1);
  endtask

  // Issue one operation and wait for its done pulse; checks latency and the
  // product against a literal supplied by the caller.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input string tag);
    int cyc = 0;
    @(negedge clk);
    start = 1'b1;
    multiplicand = a;
    multiplier = b;
    while (cyc < 30) begin
      @(negedge clk);
      if (cyc == 0) begin
        start = 1'b0;
        multiplicand = W'($urandom);
        multiplier = W'($urandom);
      end
      cyc++;
      if (done) break;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_latency"}, 32'(cyc), 32'(W + 1));
    check({tag, "_product"}, 32'(product), 32'(exp_p));
  endtask

  initial begin
    int ndone;
    int last;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    rst_n = 1'b1;

    // Directed cases with hand-computed products.
    run_op(8'd13, 8'd11, 16'h008F, "a13b11");
    repeat (3) @(negedge clk);
    check("hold_product", 32'(product), 32'h008F);
    run_op(8'd255, 8'd255, 16'hFE01, "max");
    run_op(8'd0, 8'd200, 16'h0000, "a_zero");
    run_op(8'd200, 8'd0, 16'h0000, "b_zero");
    for (int k = 0; k < W; k++) begin
      run_op(8'h5A, W'(1 << k), 16'h005A << k, "pow2");
    end

    // start re-asserted mid-run with other operands must be ignored.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'h21; multiplier = 8'h13;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; multiplicand = 8'hFF; multiplier = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ignored_start_product", 32'(product), 32'h0273);
      end
    end
    check("ignored_start_done_count", 32'(ndone), 32'd1);

    // start held high: a new operation every W+1 cycles.
    @(negedge clk);
    start = 1'b1;
    multiplicand = W'($urandom);
    multiplier = W'($urandom);
    ndone = 0;
    last = -1;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (done) begin
        if (last >= 0) check("b2b_gap", 32'(i - last), 32'(W + 1));
        last = i;
        ndone++;
      end
      multiplicand = W'($urandom);
      multiplier = W'($urandom);
    end
    start = 1'b0;
    check("b2b_done_count", 32'(ndone >= 4), 32'd1);
    wait_idle();

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd77; multiplier = 8'd99;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(8'd77, 8'd99, 16'h1DC7, "after_rst");

    // Randomized operations with random idle gaps.
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, (2*W)'(int'(ra) * int'(rb)), "rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
